// File: rtl/cont_dato_pkg.sv
// Shared types for the up/down counter: repeat FSM states, BCD width and the
// binary-to-BCD helper used for the display output.
package cont_dato_pkg;

  localparam int BCD_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RPT  = 2'd2
  } rep_state_t;

  // Counts never exceed 99, so one tens digit and one units digit suffice.
  function automatic logic [BCD_W-1:0] to_bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(v / 7'd10);
    units = 4'(v % 7'd10);
    return {tens, units};
  endfunction

endpackage

// File: rtl/cont_dato_if.sv
// Counter front-panel bundle: button/load controls in, count and wrap pulses out.
interface cont_dato_if #(
  parameter int DAT_W = 7
);
  logic                               en;
  logic                               aum;
  logic                               dism;
  logic                               load;
  logic [DAT_W-1:0]                   load_val;
  logic [DAT_W-1:0]                   dat_sal;
  logic [cont_dato_pkg::BCD_W-1:0]    bcd_sal;
  logic                               carry;
  logic                               borrow;

  modport master (
    output en, aum, dism, load, load_val,
    input  dat_sal, bcd_sal, carry, borrow
  );

  modport slave (
    input  en, aum, dism, load, load_val,
    output dat_sal, bcd_sal, carry, borrow
  );
endinterface

// File: rtl/cont_rep_fsm.sv
// Button edge detect plus hold-to-repeat FSM producing single-cycle step ticks.
// Latency: ticks are combinational from the inputs and registered edge/FSM state.
// Backpressure: none; load, en=0 or both buttons held park the FSM in IDLE.
module cont_rep_fsm
  import cont_dato_pkg::*;
#(
  parameter int REP_DLY = 50_000_000,
  parameter int REP_PER = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic aum,
  input  logic dism,
  input  logic load,
  output logic up_tick,
  output logic dn_tick
);

  localparam int HOLD_MAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
  localparam int CW       = $clog2(HOLD_MAX) + 1;
  localparam logic [CW-1:0] DLY_LAST = CW'(REP_DLY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REP_PER - 1);

  rep_state_t    state, state_nxt;
  logic          dir_up, dir_up_nxt;
  logic [CW-1:0] hold_cnt, hold_cnt_nxt;
  logic          aum_q, dism_q;
  logic          up_rise, dn_rise, held;

  assign up_rise = aum & ~aum_q & ~dism;
  assign dn_rise = dism & ~dism_q & ~aum;
  assign held    = dir_up ? (aum & ~dism) : (dism & ~aum);

  always_comb begin
    state_nxt    = state;
    dir_up_nxt   = dir_up;
    hold_cnt_nxt = hold_cnt;
    up_tick      = 1'b0;
    dn_tick      = 1'b0;
    if (load || !en || (aum && dism)) begin
      state_nxt    = IDLE;
      hold_cnt_nxt = '0;
    end else if (state != IDLE && held) begin
      if ((state == WAIT && hold_cnt == DLY_LAST) ||
          (state == RPT  && hold_cnt == PER_LAST)) begin
        up_tick      = dir_up;
        dn_tick      = ~dir_up;
        hold_cnt_nxt = '0;
        state_nxt    = RPT;
      end else begin
        hold_cnt_nxt = hold_cnt + 1'b1;
      end
    end else begin
      // A release can coincide with a fresh press of the other button.
      state_nxt    = IDLE;
      hold_cnt_nxt = '0;
      if (up_rise) begin
        up_tick    = 1'b1;
        dir_up_nxt = 1'b1;
        state_nxt  = WAIT;
      end else if (dn_rise) begin
        dn_tick    = 1'b1;
        dir_up_nxt = 1'b0;
        state_nxt  = WAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      dir_up   <= 1'b0;
      hold_cnt <= '0;
      aum_q    <= 1'b0;
      dism_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      dir_up   <= dir_up_nxt;
      hold_cnt <= hold_cnt_nxt;
      aum_q    <= aum;
      dism_q   <= dism;
    end
  end

endmodule

// File: rtl/cont_dato.sv
// Wrapping MIN_VAL..MAX_VAL up/down counter with load, auto-repeat and BCD view.
// Latency: count moves on the edge that samples the step/load; wrap pulses same edge.
// Backpressure: none; load beats en=0 beats a step.
module cont_dato_mod
  import cont_dato_pkg::*;
#(
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 12,
  parameter int DAT_W   = 7,
  parameter int REP_DLY = 50_000_000,
  parameter int REP_PER = 10_000_000
) (
  input logic         clk,
  input logic         reset,
  cont_dato_if.slave  bus
);

  localparam logic [DAT_W-1:0] MIN_C = DAT_W'(MIN_VAL);
  localparam logic [DAT_W-1:0] MAX_C = DAT_W'(MAX_VAL);

  logic [DAT_W-1:0] count;
  logic [DAT_W-1:0] load_clamped;
  logic             carry_q, borrow_q;
  logic             up_tick, dn_tick;

  cont_rep_fsm #(
    .REP_DLY (REP_DLY),
    .REP_PER (REP_PER)
  ) u_rep (
    .clk     (clk),
    .reset   (reset),
    .en      (bus.en),
    .aum     (bus.aum),
    .dism    (bus.dism),
    .load    (bus.load),
    .up_tick (up_tick),
    .dn_tick (dn_tick)
  );

  always_comb begin
    load_clamped = bus.load_val;
    if (bus.load_val < MIN_C)      load_clamped = MIN_C;
    else if (bus.load_val > MAX_C) load_clamped = MAX_C;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= MIN_C;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      if (bus.load) begin
        count <= load_clamped;
      end else if (bus.en) begin
        if (up_tick) begin
          if (count == MAX_C) begin
            count   <= MIN_C;
            carry_q <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end else if (dn_tick) begin
          if (count == MIN_C) begin
            count    <= MAX_C;
            borrow_q <= 1'b1;
          end else begin
            count <= count - 1'b1;
          end
        end
      end
    end
  end

  assign bus.dat_sal = count;
  assign bus.bcd_sal = to_bcd(count[6:0]);
  assign bus.carry   = carry_q;
  assign bus.borrow  = borrow_q;

endmodule

// File: tb/tb_cont_dato_mod.sv
// Randomised and directed scoreboard bench for cont_dato_mod with short repeat timing.
module tb_cont_dato_mod;

  localparam int MIN_VAL = 0;
  localparam int MAX_VAL = 12;
  localparam int DAT_W   = 7;
  localparam int REP_DLY = 8;
  localparam int REP_PER = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cont_dato_if #(.DAT_W(DAT_W)) bus ();

  cont_dato_mod #(
    .MIN_VAL (MIN_VAL),
    .MAX_VAL (MAX_VAL),
    .DAT_W   (DAT_W),
    .REP_DLY (REP_DLY),
    .REP_PER (REP_PER)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int cnt;
    bit carry;
    bit borrow;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a press is a timeline; steps fall at press-time 0,
  // REP_DLY, REP_DLY+REP_PER, ... as long as the press is unbroken.
  int m_cnt;
  bit m_pa, m_pd, m_act, m_up;
  int m_t;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int bcd_of(input int c);
    return (c / 10) * 16 + (c % 10);
  endfunction

  task automatic model_step(input bit r, input bit e, input bit a, input bit d,
                            input bit l, input int lv, output exp_t x);
    bit upr, dnr, stepped, up;
    x.carry  = 0;
    x.borrow = 0;
    stepped  = 0;
    up       = 0;
    if (!r) begin
      m_cnt = MIN_VAL; m_act = 0; m_pa = 0; m_pd = 0;
      x.cnt = m_cnt;
      return;
    end
    upr = a && !m_pa && !d;
    dnr = d && !m_pd && !a;
    if (l) begin
      m_cnt = (lv < MIN_VAL) ? MIN_VAL : (lv > MAX_VAL) ? MAX_VAL : lv;
      m_act = 0;
    end else if (!e || (a && d)) begin
      m_act = 0;
    end else if (m_act && (m_up ? a : d)) begin
      m_t++;
      if (m_t == REP_DLY || (m_t > REP_DLY && (m_t - REP_DLY) % REP_PER == 0)) begin
        stepped = 1;
        up      = m_up;
      end
    end else begin
      m_act = 0;
      if (upr || dnr) begin
        m_act = 1; m_up = upr; m_t = 0;
        stepped = 1; up = upr;
      end
    end
    if (stepped) begin
      if (up) begin
        if (m_cnt == MAX_VAL) begin m_cnt = MIN_VAL; x.carry = 1; end
        else m_cnt++;
      end else begin
        if (m_cnt == MIN_VAL) begin m_cnt = MAX_VAL; x.borrow = 1; end
        else m_cnt--;
      end
    end
    m_pa  = a;
    m_pd  = d;
    x.cnt = m_cnt;
  endtask

  // Called 4 time units after a rising edge; returns at the same phase next cycle.
  task automatic cyc(input bit r, input bit e, input bit a, input bit d,
                     input bit l, input int lv);
    exp_t x;
    reset        = r;
    bus.en       = e;
    bus.aum      = a;
    bus.dism     = d;
    bus.load     = l;
    bus.load_val = DAT_W'(lv);
    model_step(r, e, a, d, l, lv, x);
    sb.push_back(x);
    if (!r) begin
      #1;
      chk("async_reset_cnt", int'(bus.dat_sal), MIN_VAL);
      chk("async_reset_carry", int'(bus.carry), 0);
    end
    @(posedge clk);
    #4;
  endtask

  // Monitor: every edge the DUT presents a new state; compare it to the oldest prediction.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("count", int'(bus.dat_sal), x.cnt);
        chk("carry", int'(bus.carry), int'(x.carry));
        chk("borrow", int'(bus.borrow), int'(x.borrow));
        chk("bcd", int'(bus.bcd_sal), bcd_of(x.cnt));
      end
    end
  end

  initial begin
    int btn;
    bit e, r, l;
    reset        = 1'b0;
    bus.en       = 1'b0;
    bus.aum      = 1'b0;
    bus.dism     = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    m_cnt = MIN_VAL; m_act = 0; m_pa = 0; m_pd = 0; m_up = 0; m_t = 0;
    #1;
    chk("reset_cnt", int'(bus.dat_sal), MIN_VAL);
    chk("reset_bcd", int'(bus.bcd_sal), bcd_of(MIN_VAL));
    chk("reset_carry", int'(bus.carry), 0);
    chk("reset_borrow", int'(bus.borrow), 0);
    @(posedge clk);
    #4;
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);

    // Wrap up from MAX and down from MIN.
    cyc(1, 1, 0, 0, 1, 12);
    cyc(1, 1, 1, 0, 0, 0);
    chk("wrap_up_cnt", int'(bus.dat_sal), 0);
    chk("wrap_up_carry", int'(bus.carry), 1);
    cyc(1, 1, 0, 0, 0, 0);
    chk("carry_one_cycle", int'(bus.carry), 0);
    cyc(1, 1, 0, 1, 0, 0);
    chk("wrap_dn_cnt", int'(bus.dat_sal), 12);
    chk("wrap_dn_borrow", int'(bus.borrow), 1);
    chk("wrap_dn_bcd", int'(bus.bcd_sal), 8'h12);
    cyc(1, 1, 0, 0, 0, 0);

    // Held button: steps at press cycles 0, 8, 12, 16.
    cyc(1, 1, 0, 0, 1, 3);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, 1, 0, 0, 0);
      if (i == 0 || i == 7)  chk("hold_first", int'(bus.dat_sal), 4);
      if (i == 8 || i == 11) chk("hold_delay", int'(bus.dat_sal), 5);
      if (i == 12)           chk("hold_rpt1", int'(bus.dat_sal), 6);
    end
    chk("hold_final", int'(bus.dat_sal), 7);
    for (int i = 0; i < 6; i++) cyc(1, 1, 0, 0, 0, 0);
    chk("hold_release", int'(bus.dat_sal), 7);

    // Load clamps and ignores en.
    cyc(1, 0, 0, 0, 1, 20);
    chk("load_clamp", int'(bus.dat_sal), 12);
    chk("load_no_carry", int'(bus.carry), 0);
    cyc(1, 0, 0, 0, 1, 5);
    chk("load_5", int'(bus.dat_sal), 5);

    // en rising under a held button, then both buttons together.
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) cyc(1, 1, 1, 0, 0, 0);
    chk("en_rise_held", int'(bus.dat_sal), 5);
    cyc(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) cyc(1, 1, 1, 1, 0, 0);
    chk("both_pressed", int'(bus.dat_sal), 5);
    cyc(1, 1, 0, 0, 0, 0);

    // Reset in the middle of auto-repeat.
    cyc(1, 1, 0, 0, 1, 6);
    for (int i = 0; i < 14; i++) cyc(1, 1, 1, 0, 0, 0);
    chk("pre_reset_cnt", int'(bus.dat_sal), 9);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    chk("post_reset_step", int'(bus.dat_sal), 1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0, 0);
    chk("post_reset_hold", int'(bus.dat_sal), 1);
    cyc(1, 1, 0, 0, 0, 0);

    // Random traffic against the model.
    btn = 0;
    e   = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: btn = 0;
          4, 5, 6:    btn = 1;
          7, 8:       btn = 2;
          default:    btn = 3;
        endcase
      end
      if ($urandom_range(0, 39) == 0) e = !e;
      l = ($urandom_range(0, 49) == 0);
      r = ($urandom_range(0, 299) != 0);
      cyc(r, e, (btn == 1 || btn == 3), (btn >= 2), l, int'($urandom_range(0, 20)));
    end
    cyc(1, 1, 0, 0, 0, 0);

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    chk("scoreboard_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
